// File: rtl/clock_period_monitor.sv
`timescale 1ns / 100ps
`default_nettype none
// ============================================================================
//  Module   : clock_period_monitor
//  Purpose  : Measures the period of a slow free-running input in clk_in
//             cycles, strobes each measurement, flags loss and lock.
//             Optional macro PERIOD_CHECK_EN adds the tolerance comparator.
//  Revision : 1.0  initial release
// ============================================================================
module clock_period_monitor #(
    parameter int EXPECTED  = 100000000,
    parameter int TOLERANCE = 1000,
    parameter int TIMEOUT   = 200000000,
    parameter int CNT_W     = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             clk_slow,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             lost,
    output logic             locked
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_max      = '1;

    logic             r_s1, r_s2, r_s3;
    logic             w_rise;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_meas;
    state_t           r_state, w_state_nxt;
    logic             r_edge_pulse;
    logic [CNT_W-1:0] r_period, w_period_nxt;
    logic             r_period_valid, w_valid_nxt;
    logic             r_lost, w_lost_nxt;
    logic             w_timeout;

    assign w_rise = r_s2 & ~r_s3;
    assign w_meas = r_cnt + CNT_W'(1);
    // A rise on the timeout cycle takes priority, so it never counts as loss.
    assign w_timeout = (r_state != S_IDLE) && !w_rise && (r_cnt == c_timeout_last);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_edge_pulse <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_s1         <= clk_slow;
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            r_edge_pulse <= w_rise;
            if (w_rise) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= w_meas;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_lost         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_period       <= w_period_nxt;
            r_period_valid <= w_valid_nxt;
            r_lost         <= w_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_period_nxt = r_period;
        w_valid_nxt  = 1'b0;
        w_lost_nxt   = r_lost;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_ARMED;
                    w_lost_nxt  = 1'b0;
                end
            end
            S_ARMED, S_RUN: begin
                if (w_rise) begin
                    w_state_nxt  = S_RUN;
                    w_period_nxt = w_meas;
                    w_valid_nxt  = 1'b1;
                    w_lost_nxt   = 1'b0;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_lost_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef PERIOD_CHECK_EN
    localparam logic [CNT_W:0] c_expected  = (CNT_W + 1)'(EXPECTED);
    localparam logic [CNT_W:0] c_tolerance = (CNT_W + 1)'(TOLERANCE);

    logic [CNT_W:0] w_meas_ext;
    logic [CNT_W:0] w_diff;
    logic           w_in_tol;
    logic           r_locked;

    // Judge the value being loaded into period, so lock tracks it in the same cycle.
    always_comb begin
        w_meas_ext = {1'b0, w_meas};
        w_diff     = (w_meas_ext >= c_expected) ? (w_meas_ext - c_expected)
                                                : (c_expected - w_meas_ext);
        w_in_tol   = (w_diff <= c_tolerance);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_locked <= 1'b0;
        end else if (w_valid_nxt) begin
            r_locked <= w_in_tol;
        end else if (w_timeout) begin
            r_locked <= 1'b0;
        end
    end

    assign locked = r_locked;
`else
    assign locked = (r_state == S_RUN);
`endif

    assign edge_pulse   = r_edge_pulse;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign lost         = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_clock_period_monitor.sv
`timescale 1ns / 100ps
`default_nettype none
// ============================================================================
//  Module   : tb_clock_period_monitor
//  Purpose  : Directed scoreboard bench for clock_period_monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_period_monitor;

    localparam int EXP_P = 20;
    localparam int TOL   = 2;
    localparam int TMO   = 50;
    localparam int W     = 8;

    logic         clk_in = 1'b0;
    logic         reset  = 1'b1;
    logic         clk_slow = 1'b0;
    logic         edge_pulse;
    logic [W-1:0] period;
    logic         period_valid;
    logic         lost;
    logic         locked;

    clock_period_monitor #(
        .EXPECTED (EXP_P),
        .TOLERANCE(TOL),
        .TIMEOUT  (TMO),
        .CNT_W    (W)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .clk_slow    (clk_slow),
        .edge_pulse  (edge_pulse),
        .period      (period),
        .period_valid(period_valid),
        .lost        (lost),
        .locked      (locked)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int   p;
        logic lk;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_rise = 0;
    bit   have_prev = 1'b0;
    int   ep_total = 0;
    int   ep_since_rst = 0;
    bit   seen_valid = 1'b0;
    int   last_ep_cyc = 0;
    int   lost_cycles = 0;
    bit   async_mode = 1'b0;
    int   async_valids = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected lock state for a measured period D.
    function automatic logic lock_for(input int d);
`ifdef PERIOD_CHECK_EN
        return (d >= EXP_P - TOL) && (d <= EXP_P + TOL);
`else
        return 1'b1;
`endif
    endfunction

    task automatic drive_rise();
        exp_t e;
        clk_slow = 1'b1;
        if (have_prev && (cyc - last_rise) <= TMO) begin
            e.p  = cyc - last_rise;
            e.lk = lock_for(e.p);
            sb.push_back(e);
        end
        have_prev = 1'b1;
        last_rise = cyc;
    endtask

    task automatic square(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            drive_rise();
            repeat (hi) @(negedge clk_in);
            clk_slow = 1'b0;
            repeat (lo) @(negedge clk_in);
        end
    endtask

    // A rise that must only arm the FSM: check latency and absence of a measurement.
    task automatic rise_checked(input string tag);
        drive_rise();
        repeat (2) @(negedge clk_in);
        chk({tag, "_ep_early"}, edge_pulse, 1'b0);
        @(negedge clk_in);
        chk({tag, "_ep"}, edge_pulse, 1'b1);
        chk({tag, "_no_valid"}, period_valid, 1'b0);
        chk({tag, "_lost_clr"}, lost, 1'b0);
        repeat (7) @(negedge clk_in);
        clk_slow = 1'b0;
        repeat (10) @(negedge clk_in);
    endtask

    task automatic wait_lost(input string tag);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (lost) break;
        end
        chk({tag, "_lost_timeout"}, lost, 1'b1);
    endtask

    always @(negedge clk_in) begin
        if (!reset) begin
            if (edge_pulse) begin
                ep_total++;
                ep_since_rst++;
                last_ep_cyc = cyc;
            end
            if (lost) lost_cycles++;
            if (period_valid) begin
                chk("valid_with_edge", edge_pulse, 1'b1);
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    chk("first_valid_edge_idx", ep_since_rst, 2);
                end
                if (async_mode) begin
                    async_valids++;
                    chk("async_period_20_21", (period == 8'd20) || (period == 8'd21), 1'b1);
                end else begin
                    chk("valid_expected", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("period", period, e.p);
                        chk("locked", locked, e.lk);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        int ep0;
        repeat (3) @(negedge clk_in);
        chk("rst_edge_pulse", edge_pulse, 1'b0);
        chk("rst_period", period, 0);
        chk("rst_valid", period_valid, 1'b0);
        chk("rst_lost", lost, 1'b0);
        chk("rst_locked", locked, 1'b0);
        reset = 1'b0;
        @(negedge clk_in);

        rise_checked("first");
        square(10, 10, 5);
        chk("sb_empty_p20", sb.size(), 0);
        square(12, 12, 4);
        chk("sb_empty_p24", sb.size(), 0);
        square(11, 10, 3);
        chk("sb_empty_p21", sb.size(), 0);
        square(10, 10, 3);
        chk("sb_empty_p20b", sb.size(), 0);

        wait_lost("stop");
        chk("lost_delay", cyc - last_ep_cyc, TMO);
        chk("lost_locked", locked, 1'b0);
        chk("lost_period_hold", period, 20);

        rise_checked("recover");
        chk("lost_cleared", lost, 1'b0);

        lc = lost_cycles;
        square(25, 25, 2);
        square(10, 10, 1);
        chk("sb_empty_p50", sb.size(), 0);
        chk("p50_no_lost", lost_cycles, lc);

        square(10, 10, 3);
        repeat (3) @(negedge clk_in);
        chk("pre_reset_locked", locked, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_edge", edge_pulse, 1'b0);
        chk("async_rst_period", period, 0);
        chk("async_rst_valid", period_valid, 1'b0);
        chk("async_rst_lost", lost, 1'b0);
        chk("async_rst_locked", locked, 1'b0);
        repeat (3) @(negedge clk_in);
        sb.delete();
        have_prev    = 1'b0;
        seen_valid   = 1'b0;
        ep_since_rst = 0;
        reset = 1'b0;
        @(negedge clk_in);
        rise_checked("post_rst");
        square(10, 10, 2);
        chk("sb_empty_post_rst", sb.size(), 0);

        wait_lost("pre_async");
        async_mode = 1'b1;
        ep0 = ep_total;
        #0.3;
        for (int i = 0; i < 30; i++) begin
            clk_slow = 1'b1;
            #101.5;
            clk_slow = 1'b0;
            #101.5;
        end
        repeat (10) @(negedge clk_in);
        async_mode = 1'b0;
        chk("async_edge_count", ep_total - ep0, 30);
        chk("async_valid_count", async_valids, 29);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_period_monitor.md
# clock_period_monitor

Measures the period of a slow, free-running square wave (typically the toggled output of our clock divider, or an external slow clock) in `clk_in` cycles. Synchronizes the input into the `clk_in` domain, detects rising edges, reports each full-period measurement with a one-cycle valid strobe, and flags loss of the input. Sits beside the divider as its checker/consumer, and drives status LEDs and the seven-segment readout.

## Interface
- `EXPECTED`, 100000000: nominal period in `clk_in` cycles (1 Hz at 100 MHz).
- `TOLERANCE`, 1000: allowed absolute deviation from `EXPECTED` for lock.
- `TIMEOUT`, 200000000: cycles without a rising edge before `lost` asserts. Must be > `EXPECTED` and < 2^`CNT_W`.
- `CNT_W`, 32: counter and period width.

Ports:
- `clk_in` in 1: system clock. Reset is asynchronous, active-high; clock is `clk_in`.
- `reset` in 1: asynchronous, active-high.
- `clk_slow` in 1: monitored signal, asynchronous to `clk_in`.
- `edge_pulse` out 1: one-cycle strobe per detected rising edge.
- `period` out `CNT_W`: last measured period in `clk_in` cycles.
- `period_valid` out 1: one-cycle strobe when `period` updates.
- `lost` out 1: input declared absent.
- `locked` out 1: measurements within tolerance.

## Operation
- Synchronizer: `s1 <= clk_slow`, `s2 <= s1`, `s3 <= s2`. Rise = `s2 & ~s3`. `edge_pulse` is rise, registered.
- Counter `cnt` (`CNT_W` bits): cleared to 0 on every rise, otherwise increments. Saturates at all-ones and never wraps.
- FSM states:
  - IDLE: no edge since reset/loss. On rise -> ARMED, `cnt` <= 0, `lost` <= 0.
  - ARMED: first edge seen. On rise -> RUN, `period` <= `cnt`+1, `period_valid` pulse.
  - RUN: on rise -> stay, `period` <= `cnt`+1, `period_valid` pulse.
- Timeout in ARMED/RUN: when `cnt` == `TIMEOUT`-1 and no rise occurs -> IDLE, `lost` <= 1, `locked` <= 0. `lost` stays high until the next rise.
- A rise on the same cycle as the timeout condition wins: measure, no `lost`.
- `period` holds its last value across timeout. It is only cleared by reset.
- Rises D `clk_in` cycles apart yield `period` = D.

## Timing
- Reset values: `s1`..`s3`=0, `cnt`=0, state=IDLE, `edge_pulse`=0, `period`=0, `period_valid`=0, `lost`=0, `locked`=0.
- Edge latency: `edge_pulse` is high in the cycle after the 3rd `clk_in` edge, counting the first edge that samples `clk_slow` high.
- `period_valid` and the `period` update are coincident with `edge_pulse`.
- `locked` updates in that same cycle.
- Inputs high or low for fewer than 2 `clk_in` cycles may be missed. No glitch filtering.
- Reset mid-measurement returns all state to reset values immediately. The first edge after reset only arms the FSM and produces no measurement.

## Configuration
- `PERIOD_CHECK_EN` defined:
  - On each `period_valid`, `locked` <= 1 if |`period`-`EXPECTED`| <= `TOLERANCE`, else 0.
  - The difference is computed unsigned in `CNT_W`+1 bits as max−min.
  - `locked` is cleared on timeout.
- `PERIOD_CHECK_EN` undefined: `locked` = 1 exactly while state == RUN. No comparator is built, and `EXPECTED`/`TOLERANCE` are unused.

## Test plan
All tests use `EXPECTED`=20, `TOLERANCE`=2, `TIMEOUT`=50, `CNT_W`=8.
- Reset, then drive a square wave with period 20 cycles (10 high/10 low):
  - First `period_valid` occurs on the 2nd `edge_pulse`.
  - `period`=20 thereafter.
  - With `PERIOD_CHECK_EN`, `locked`=1 from the 2nd edge.
- Period 24: `period`=24. With `PERIOD_CHECK_EN`, `locked`=0; without it, `locked`=1. Returning to period 21 sets `locked`=1.
- Stop `clk_slow` after lock:
  - `lost`=1 exactly 50 cycles after the last `edge_pulse`, with `locked`=0 and `period` still 20.
  - The next rise clears `lost` and gives no `period_valid`.
  - The following rise measures again.
- Arrange a rise to be detected on the same cycle `cnt`==49: `period_valid`=1, `period`=50, `lost` stays 0.
- Assert `reset` mid-period while RUN/locked: all outputs go 0 immediately. The first post-reset edge produces `edge_pulse` only.
- Toggle `clk_slow` asynchronously to `clk_in` (period ~20.3 cycles): `period` ∈ {20,21}, and every rise yields exactly one `edge_pulse`.
